// File: rtl/pkt_rx_unloader_if.sv
// Bundle of the MAC RX read port and the downstream valid/ready stream.
// The unloader takes the slave view; the MAC plus the consumer take the master view.
interface pkt_rx_unloader_if;
    logic        pkt_rx_avail;
    logic        pkt_rx_ren;
    logic        pkt_rx_val;
    logic        pkt_rx_sop;
    logic        pkt_rx_eop;
    logic        pkt_rx_err;
    logic [63:0] pkt_rx_data;
    logic [2:0]  pkt_rx_mod;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic        out_err;
    logic [2:0]  out_mod;

    modport master (
        output pkt_rx_avail, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err,
               pkt_rx_data, pkt_rx_mod, out_ready,
        input  pkt_rx_ren, out_valid, out_data, out_sop, out_eop, out_err, out_mod
    );

    modport slave (
        input  pkt_rx_avail, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err,
               pkt_rx_data, pkt_rx_mod, out_ready,
        output pkt_rx_ren, out_valid, out_data, out_sop, out_eop, out_err, out_mod
    );
endinterface

// File: rtl/pkt_rx_unloader.sv
// Pulls packets out of a MAC RX buffer into a 4-entry FIFO feeding a valid/ready stream,
// with packet framing checks, length tracking and statistics.
module pkt_rx_unloader #(
    parameter int CNT_W = 32
) (
    input  logic             clk_156m25,
    input  logic             reset_156m25_n,
    pkt_rx_unloader_if.slave bus,
    output logic [CNT_W-1:0] stat_pkt_cnt,
    output logic [CNT_W-1:0] stat_err_cnt,
    output logic [CNT_W-1:0] stat_drop_cnt,
    output logic [15:0]      last_len,
    output logic             proto_err
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic        err;
        logic [2:0]  mod;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             ren_q, ren_d;
    entry_t           fifo_q [4];
    logic [1:0]       wr_ptr_q, rd_ptr_q;
    logic [2:0]       count_q, count_d;
    logic             in_pkt_q;
    logic [15:0]      len_q, len_d;
    logic             err_seen_q;
    logic [CNT_W-1:0] pkt_cnt_q, err_cnt_q, drop_cnt_q;
    logic [15:0]      last_len_q;
    logic             proto_err_q;

    logic             fifo_full, fifo_empty;
    logic             push, pop, drop;
    logic             err_acc;
    logic [3:0]       word_bytes;
    logic [16:0]      len_sum;
    entry_t           rx_word, head;

    always_comb begin
        rx_word    = '{data: bus.pkt_rx_data, sop: bus.pkt_rx_sop, eop: bus.pkt_rx_eop,
                       err: bus.pkt_rx_err, mod: bus.pkt_rx_mod};
        fifo_full  = (count_q == 3'd4);
        fifo_empty = (count_q == 3'd0);
        pop        = !fifo_empty && bus.out_ready;
        // A word is stored only if there is room and it belongs to a packet.
        push       = bus.pkt_rx_val && !fifo_full && (bus.pkt_rx_sop || in_pkt_q);
        drop       = bus.pkt_rx_val && !push;
        count_d    = count_q + {2'b00, push} - {2'b00, pop};

        word_bytes = (bus.pkt_rx_eop && bus.pkt_rx_mod != 3'd0) ? {1'b0, bus.pkt_rx_mod} : 4'd8;
        len_sum    = (bus.pkt_rx_sop ? 17'd0 : {1'b0, len_q}) + {13'd0, word_bytes};
        len_d      = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        err_acc    = (bus.pkt_rx_sop ? 1'b0 : err_seen_q) | bus.pkt_rx_err;

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.pkt_rx_avail) state_d = ST_READ;
            ST_READ: if (bus.pkt_rx_val && bus.pkt_rx_eop && !bus.pkt_rx_avail) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Next cycle's in-flight read is this cycle's ren, so budget against count_d + ren_q.
        ren_d = (state_d == ST_READ) && (({1'b0, count_d} + {3'b000, ren_q}) <= 4'd2);
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
        end else if (push) begin
            fifo_q[wr_ptr_q] <= rx_word;
        end
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state_q     <= ST_IDLE;
            ren_q       <= 1'b0;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            in_pkt_q    <= 1'b0;
            len_q       <= 16'd0;
            err_seen_q  <= 1'b0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            last_len_q  <= 16'd0;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ren_q   <= ren_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;

            if (drop) begin
                drop_cnt_q  <= drop_cnt_q + CNT_ONE;
                proto_err_q <= 1'b1;
            end

            if (push) begin
                // An sop inside a packet silently truncates the previous one.
                if (bus.pkt_rx_sop && in_pkt_q) proto_err_q <= 1'b1;
                len_q      <= len_d;
                err_seen_q <= err_acc;
                if (bus.pkt_rx_eop) begin
                    in_pkt_q   <= 1'b0;
                    last_len_q <= len_d;
                    pkt_cnt_q  <= pkt_cnt_q + CNT_ONE;
                    if (err_acc) err_cnt_q <= err_cnt_q + CNT_ONE;
                end else begin
                    in_pkt_q <= 1'b1;
                end
            end
        end
    end

    assign head          = fifo_q[rd_ptr_q];
    assign bus.pkt_rx_ren = ren_q;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_empty ? 64'd0 : head.data;
    assign bus.out_sop   = !fifo_empty && head.sop;
    assign bus.out_eop   = !fifo_empty && head.eop;
    assign bus.out_err   = !fifo_empty && head.err;
    assign bus.out_mod   = fifo_empty ? 3'd0 : head.mod;

    assign stat_pkt_cnt  = pkt_cnt_q;
    assign stat_err_cnt  = err_cnt_q;
    assign stat_drop_cnt = drop_cnt_q;
    assign last_len      = last_len_q;
    assign proto_err     = proto_err_q;
endmodule

// File: tb/tb_pkt_rx_unloader.sv
// Bench for pkt_rx_unloader: a queue-based MAC model answers ren, and a packet-level
// reference model predicts every output each cycle.
module tb_pkt_rx_unloader;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pkt_rx_unloader_if bus ();
    logic [CNT_W-1:0] stat_pkt_cnt, stat_err_cnt, stat_drop_cnt;
    logic [15:0]      last_len;
    logic             proto_err;

    pkt_rx_unloader #(.CNT_W(CNT_W)) dut (
        .clk_156m25    (clk),
        .reset_156m25_n(rst_n),
        .bus           (bus),
        .stat_pkt_cnt  (stat_pkt_cnt),
        .stat_err_cnt  (stat_err_cnt),
        .stat_drop_cnt (stat_drop_cnt),
        .last_len      (last_len),
        .proto_err     (proto_err)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic        err;
        logic [2:0]  mod;
    } word_t;

    word_t macq[$];
    word_t expq[$];

    int n_cmp = 0;
    int n_bad = 0;

    bit          m_in_pkt, m_reading, m_prev_ren, m_proto, m_errs, exp_ren;
    int          m_len;
    logic [31:0] m_pkt, m_errc, m_drop;
    logic [15:0] m_last;
    bit          ren_seen;
    bit          prev_valid, prev_err;
    int          dut_pops, dut_err_pops, pkt_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        expq.delete();
        macq.delete();
        m_in_pkt = 0; m_reading = 0; m_prev_ren = 0; m_proto = 0; m_errs = 0; exp_ren = 0;
        m_len = 0; m_pkt = 0; m_errc = 0; m_drop = 0; m_last = 0;
        ren_seen = 0; prev_valid = 0; prev_err = 0;
    endtask

    task automatic drive_idle();
        bus.pkt_rx_val  = 1'b0;
        bus.pkt_rx_sop  = 1'b0;
        bus.pkt_rx_eop  = 1'b0;
        bus.pkt_rx_err  = 1'b0;
        bus.pkt_rx_mod  = 3'd0;
        bus.pkt_rx_data = 64'd0;
        bus.pkt_rx_avail = 1'b0;
    endtask

    // Applies the edge that just happened, using the inputs the DUT sampled.
    task automatic model_step();
        int    pre;
        bit    pop;
        word_t w, h;
        pre = expq.size();
        pop = (pre > 0) && bus.out_ready;
        w   = '{data: bus.pkt_rx_data, sop: bus.pkt_rx_sop, eop: bus.pkt_rx_eop,
                err: bus.pkt_rx_err, mod: bus.pkt_rx_mod};
        if (prev_valid && bus.out_ready) begin
            dut_pops++;
            if (prev_err) dut_err_pops++;
        end
        if (pop) begin
            h = expq.pop_front();
            if (h.eop) begin
                pkt_seen++;
                $display("tb: packet end %0d delivered, data=%h mod=%0d err=%0d", pkt_seen, h.data, h.mod, h.err);
            end
        end
        if (bus.pkt_rx_val) begin
            if (pre == 4 || (!w.sop && !m_in_pkt)) begin
                m_drop++;
                m_proto = 1;
            end else begin
                if (w.sop) begin
                    if (m_in_pkt) m_proto = 1;
                    m_len  = 0;
                    m_errs = 0;
                end
                m_len += (w.eop && w.mod != 0) ? int'(w.mod) : 8;
                if (m_len > 65535) m_len = 65535;
                m_errs |= w.err;
                if (w.eop) begin
                    m_last = 16'(m_len);
                    m_pkt++;
                    if (m_errs) m_errc++;
                    m_in_pkt = 0;
                end else begin
                    m_in_pkt = 1;
                end
                expq.push_back(w);
            end
        end
        if (!m_reading && bus.pkt_rx_avail) m_reading = 1;
        else if (m_reading && bus.pkt_rx_val && bus.pkt_rx_eop && !bus.pkt_rx_avail) m_reading = 0;
        exp_ren    = m_reading && ((expq.size() + int'(m_prev_ren)) <= 2);
        m_prev_ren = exp_ren;
    endtask

    task automatic compare();
        chk("ren", bus.pkt_rx_ren, exp_ren);
        chk("out_valid", bus.out_valid, expq.size() > 0);
        if (expq.size() > 0) begin
            chk("out_data", bus.out_data, expq[0].data);
            chk("out_sop", bus.out_sop, expq[0].sop);
            chk("out_eop", bus.out_eop, expq[0].eop);
            chk("out_err", bus.out_err, expq[0].err);
            chk("out_mod", bus.out_mod, expq[0].mod);
        end
        chk("stat_pkt_cnt", stat_pkt_cnt, m_pkt);
        chk("stat_err_cnt", stat_err_cnt, m_errc);
        chk("stat_drop_cnt", stat_drop_cnt, m_drop);
        chk("last_len", last_len, m_last);
        chk("proto_err", proto_err, m_proto);
        prev_valid = bus.out_valid;
        prev_err   = bus.out_err;
    endtask

    // MAC answers a read issued in the previous cycle.
    task automatic mac_drive();
        word_t w;
        bit    av;
        if (ren_seen && macq.size() > 0) begin
            w = macq.pop_front();
            bus.pkt_rx_val  = 1'b1;
            bus.pkt_rx_sop  = w.sop;
            bus.pkt_rx_eop  = w.eop;
            bus.pkt_rx_err  = w.err;
            bus.pkt_rx_mod  = w.mod;
            bus.pkt_rx_data = w.data;
        end else begin
            bus.pkt_rx_val  = 1'b0;
            bus.pkt_rx_sop  = 1'b0;
            bus.pkt_rx_eop  = 1'b0;
            bus.pkt_rx_err  = 1'b0;
            bus.pkt_rx_mod  = 3'd0;
            bus.pkt_rx_data = 64'd0;
        end
        av = 0;
        foreach (macq[i]) if (macq[i].eop) av = 1;
        bus.pkt_rx_avail = av;
        ren_seen = bus.pkt_rx_ren;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                model_reset();
                drive_idle();
                continue;
            end
            model_step();
            compare();
            mac_drive();
        end
    end

    task automatic send_pkt(input int n, input int mod, input int err_idx, input bit no_sop, input int mid_sop);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.data = {$urandom(), $urandom()};
            w.sop  = (i == 0 && !no_sop) || (i == mid_sop);
            w.eop  = (i == n - 1);
            w.err  = (i == err_idx);
            w.mod  = w.eop ? 3'(mod) : 3'($urandom_range(0, 7));
            macq.push_back(w);
        end
    endtask

    task automatic wait_drain(input int budget, input bit rand_ready);
        int c;
        c = 0;
        while (!(macq.size() == 0 && expq.size() == 0 && !bus.pkt_rx_val && !bus.pkt_rx_ren && !ren_seen)
               && c < budget) begin
            @(negedge clk);
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
            c++;
        end
        if (c >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d cycles, expected drain within %0d", c, budget);
        end
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n, kind, eidx, msop;
        bit nsop;
        model_reset();
        drive_idle();
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_ren", bus.pkt_rx_ren, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_pkt_cnt", stat_pkt_cnt, 0);
        chk("rst_drop_cnt", stat_drop_cnt, 0);
        chk("rst_last_len", last_len, 0);
        chk("rst_proto_err", proto_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three-word packet, eop mod 5.
        bus.out_ready = 1'b1;
        dut_pops = 0;
        send_pkt(3, 5, -1, 0, -1);
        wait_drain(200, 0);
        chk("t1_last_len", last_len, 21);
        chk("t1_pkt_cnt", stat_pkt_cnt, 1);
        chk("t1_proto_err", proto_err, 0);
        chk("t1_words", dut_pops, 3);

        // Single-word packet, mod 0 means 8 bytes.
        send_pkt(1, 0, -1, 0, -1);
        wait_drain(200, 0);
        chk("t2_last_len", last_len, 8);
        chk("t2_pkt_cnt", stat_pkt_cnt, 2);

        // Error flagged on the middle word only.
        dut_err_pops = 0;
        send_pkt(3, 2, 1, 0, -1);
        wait_drain(200, 0);
        chk("t3_err_cnt", stat_err_cnt, 1);
        chk("t3_err_words", dut_err_pops, 1);
        chk("t3_last_len", last_len, 18);

        // Back-pressure: reads must stop without drops.
        bus.out_ready = 1'b0;
        send_pkt(10, 3, -1, 0, -1);
        repeat (30) @(negedge clk);
        chk("t4_ren_stopped", bus.pkt_rx_ren, 0);
        chk("t4_valid_held", bus.out_valid, 1);
        chk("t4_no_drop", stat_drop_cnt, 0);
        bus.out_ready = 1'b1;
        wait_drain(300, 0);
        chk("t4_pkt_cnt", stat_pkt_cnt, 4);
        chk("t4_last_len", last_len, 75);

        // Stray word with no sop after idle.
        send_pkt(1, 4, -1, 1, -1);
        wait_drain(200, 0);
        chk("t5_drop_cnt", stat_drop_cnt, 1);
        chk("t5_proto_err", proto_err, 1);
        chk("t5_out_valid", bus.out_valid, 0);
        chk("t5_pkt_cnt", stat_pkt_cnt, 4);

        // Randomised traffic with occasional framing faults and random back-pressure.
        for (int p = 0; p < 200; p++) begin
            n    = $urandom_range(1, 12);
            kind = $urandom_range(0, 19);
            eidx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            nsop = (kind == 0);
            msop = (kind == 1 && n > 1) ? $urandom_range(1, n - 1) : -1;
            send_pkt(n, $urandom_range(0, 7), eidx, nsop, msop);
        end
        wait_drain(20000, 1);

        // Reset in the middle of a packet with three words buffered.
        bus.out_ready = 1'b0;
        send_pkt(8, 1, -1, 0, -1);
        begin
            int c;
            c = 0;
            while (expq.size() != 3 && c < 100) begin
                @(negedge clk);
                c++;
            end
            chk("t6_fill_reached", expq.size(), 3);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", bus.out_valid, 0);
        chk("t6_rst_ren", bus.pkt_rx_ren, 0);
        chk("t6_rst_data", bus.out_data, 0);
        chk("t6_rst_sop", bus.out_sop, 0);
        chk("t6_rst_pkt_cnt", stat_pkt_cnt, 0);
        chk("t6_rst_drop_cnt", stat_drop_cnt, 0);
        chk("t6_rst_last_len", last_len, 0);
        chk("t6_rst_proto_err", proto_err, 0);
        macq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b1;
        send_pkt(2, 4, -1, 0, -1);
        wait_drain(200, 0);
        chk("t6_pkt_cnt", stat_pkt_cnt, 1);
        chk("t6_last_len", last_len, 12);
        chk("t6_drop_cnt", stat_drop_cnt, 0);
        chk("t6_proto_err", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
